axi4l_regbank: RTL

AXI4L_REGBANK -- requirements
Module: axi4l_regbank

---
 rtl/axi4l_regbank.sv | 129 ++++++++++++
 1 files changed

// File: rtl/axi4l_regbank.sv
// Small register bank: ID, SCRATCH, CTRL, STATUS, IRQ_STAT/IRQ_MASK and an optional timer.
// Define AXI4L_REGBANK_TIMER_EN to include the 64-bit free-running timer at indices 6/7.
module axi4l_regbank #(
  parameter int          C_ADDR_WIDTH = 12,
  parameter logic [31:0] C_ID         = 32'h0001_0000
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [C_ADDR_WIDTH-3:0] wr_addr,
  input  logic                    wr_req,
  input  logic [3:0]              wr_be,
  input  logic [31:0]             wr_data,
  output logic                    wr_ack,
  input  logic [C_ADDR_WIDTH-3:0] rd_addr,
  input  logic                    rd_req,
  output logic [31:0]             rd_data,
  output logic                    rd_ack,
  output logic [7:0]              ctrl,
  input  logic [7:0]              status,
  input  logic [7:0]              irq_evt,
  output logic                    irq
);

  localparam int AW = C_ADDR_WIDTH - 2;

  localparam logic [AW-1:0] IDX_ID       = AW'(0);
  localparam logic [AW-1:0] IDX_SCRATCH  = AW'(1);
  localparam logic [AW-1:0] IDX_CTRL     = AW'(2);
  localparam logic [AW-1:0] IDX_STATUS   = AW'(3);
  localparam logic [AW-1:0] IDX_IRQ_STAT = AW'(4);
  localparam logic [AW-1:0] IDX_IRQ_MASK = AW'(5);
`ifdef AXI4L_REGBANK_TIMER_EN
  localparam logic [AW-1:0] IDX_TIMER_LO = AW'(6);
  localparam logic [AW-1:0] IDX_TIMER_HI = AW'(7);
`endif

  logic [31:0] scratch_q;
  logic [7:0]  ctrl_q;
  logic [7:0]  irq_stat_q;
  logic [7:0]  irq_mask_q;
  logic        irq_q;
  logic        wr_ack_q;
  logic        rd_ack_q;
  logic [31:0] rd_data_q;

  logic [31:0] scratch_nxt;
  logic [7:0]  irq_clr;
  logic [31:0] rd_mux;

`ifdef AXI4L_REGBANK_TIMER_EN
  logic [63:0] timer_q;
  logic [31:0] snap_q;
`endif

  always_comb begin
    scratch_nxt = scratch_q;
    if (wr_req && wr_addr == IDX_SCRATCH) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) scratch_nxt[b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    irq_clr = 8'h00;
    if (wr_req && wr_addr == IDX_IRQ_STAT && wr_be[0]) irq_clr = wr_data[7:0];
  end

  // Muxed from pre-edge state, so a read colliding with a write sees the old value.
  always_comb begin
    rd_mux = 32'h0;
    case (rd_addr)
      IDX_ID:       rd_mux = C_ID;
      IDX_SCRATCH:  rd_mux = scratch_q;
      IDX_CTRL:     rd_mux = {24'h0, ctrl_q};
      IDX_STATUS:   rd_mux = {24'h0, status};
      IDX_IRQ_STAT: rd_mux = {24'h0, irq_stat_q};
      IDX_IRQ_MASK: rd_mux = {24'h0, irq_mask_q};
`ifdef AXI4L_REGBANK_TIMER_EN
      IDX_TIMER_LO: rd_mux = timer_q[31:0];
      IDX_TIMER_HI: rd_mux = snap_q;
`endif
      default:      rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      scratch_q  <= 32'h0;
      ctrl_q     <= 8'h00;
      irq_stat_q <= 8'h00;
      irq_mask_q <= 8'h00;
      irq_q      <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_data_q  <= 32'h0;
    end else begin
      scratch_q  <= scratch_nxt;
      if (wr_req && wr_addr == IDX_CTRL && wr_be[0]) ctrl_q <= wr_data[7:0];
      if (wr_req && wr_addr == IDX_IRQ_MASK && wr_be[0]) irq_mask_q <= wr_data[7:0];
      irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_evt;
      irq_q      <= |(irq_stat_q & irq_mask_q);
      wr_ack_q   <= wr_req;
      rd_ack_q   <= rd_req;
      if (rd_req) rd_data_q <= rd_mux;
    end
  end

`ifdef AXI4L_REGBANK_TIMER_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      timer_q <= 64'h0;
      snap_q  <= 32'h0;
    end else begin
      timer_q <= timer_q + 64'd1;
      if (rd_req && rd_addr == IDX_TIMER_LO) snap_q <= timer_q[63:32];
    end
  end
`endif

  // Outputs are forced low for the whole reset window, including the first cycle
  // before the synchronous reset has reached the flops.
  assign wr_ack  = aresetn & wr_ack_q;
  assign rd_ack  = aresetn & rd_ack_q;
  assign rd_data = aresetn ? rd_data_q : 32'h0;
  assign ctrl    = aresetn ? ctrl_q : 8'h00;
  assign irq     = aresetn & irq_q;

endmodule
